fft_reorder: RTL and testbench

FFT_REORDER -- requirements
Module: fft_reorder

---
 rtl/fft_reorder.sv | 159 +++++++++++++++
 tb/tb_fft_reorder.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder.sv
// Reorders a NUM-lane bit-reversed FFT output stream into natural order using ping/pong frame banks.
// Optional feature: define FFT_REORDER_INDEX_EN to add the index_out port (natural bin of each output lane).
module fft_reorder #(
    parameter int WIDTH = 13,
    parameter int NUM   = 16,
    parameter int N     = 512
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    valid_in,
    input  logic signed [WIDTH-1:0] din_i     [0:NUM-1],
    input  logic signed [WIDTH-1:0] din_q     [0:NUM-1],
    output logic                    valid_out,
    output logic signed [WIDTH-1:0] dout_i    [0:NUM-1],
    output logic signed [WIDTH-1:0] dout_q    [0:NUM-1]
`ifdef FFT_REORDER_INDEX_EN
    ,
    output logic [$clog2(N)-1:0]    index_out [0:NUM-1]
`endif
);
    localparam int BEATS = N / NUM;
    localparam int BW    = $clog2(BEATS);
    localparam int LW    = $clog2(NUM);
    localparam int AW    = $clog2(N);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_READ = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [BW-1:0]      r_wr_beat;
    logic [BW-1:0]      r_rd_beat;
    logic [BW-1:0]      w_rd_beat_nxt;
    logic               r_wr_bank;
    logic               r_rd_bank;
    logic               w_req;
    logic [2*WIDTH-1:0] r_mem     [0:1][0:N-1];
    logic [AW-1:0]      w_wr_addr [0:NUM-1];
    logic [AW-1:0]      w_rd_addr [0:NUM-1];
    logic [2*WIDTH-1:0] w_rd_word [0:NUM-1];

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] x);
        logic [AW-1:0] y;
        y = '0;
        for (int k = 0; k < AW; k++) begin
            y[k] = x[AW-1-k];
        end
        return y;
    endfunction

    // Input position {beat, lane} lands at its natural bin; output reads {beat, lane} directly.
    always_comb begin
        for (int l = 0; l < NUM; l++) begin
            w_wr_addr[l] = bitrev({r_wr_beat, LW'(l)});
            w_rd_addr[l] = {r_rd_beat, LW'(l)};
            w_rd_word[l] = r_mem[r_rd_bank][w_rd_addr[l]];
        end
    end

    // A read frame is requested by the capture of the last beat of an input frame.
    assign w_req = valid_in && (r_wr_beat == LAST_BEAT);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_beat <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
        end else if (valid_in) begin
            r_wr_beat <= r_wr_beat + 1'b1;
            if (w_req) begin
                r_wr_bank <= ~r_wr_bank;
                r_rd_bank <= r_wr_bank;
            end
        end
    end

    // Bank storage is deliberately not reset; a reset only abandons frames in flight.
    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int l = 0; l < NUM; l++) begin
                r_mem[r_wr_bank][w_wr_addr[l]] <= {din_i[l], din_q[l]};
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_rd_beat <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rd_beat <= w_rd_beat_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_rd_beat_nxt = r_rd_beat;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_state_nxt   = ST_READ;
                    w_rd_beat_nxt = '0;
                end
            end
            ST_READ: begin
                // The beat counter wraps to 0, so a pending request continues seamlessly.
                w_rd_beat_nxt = r_rd_beat + 1'b1;
                if ((r_rd_beat == LAST_BEAT) && !w_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_rd_beat_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_out <= 1'b0;
            for (int l = 0; l < NUM; l++) begin
                dout_i[l] <= '0;
                dout_q[l] <= '0;
            end
        end else if (r_state == ST_READ) begin
            valid_out <= 1'b1;
            for (int l = 0; l < NUM; l++) begin
                dout_i[l] <= $signed(w_rd_word[l][2*WIDTH-1:WIDTH]);
                dout_q[l] <= $signed(w_rd_word[l][WIDTH-1:0]);
            end
        end else begin
            valid_out <= 1'b0;
            for (int l = 0; l < NUM; l++) begin
                dout_i[l] <= '0;
                dout_q[l] <= '0;
            end
        end
    end

`ifdef FFT_REORDER_INDEX_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int l = 0; l < NUM; l++) begin
                index_out[l] <= '0;
            end
        end else begin
            for (int l = 0; l < NUM; l++) begin
                index_out[l] <= (r_state == ST_READ) ? w_rd_addr[l] : '0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fft_reorder.sv
// Self-checking bench for fft_reorder: randomized frames against an array-based reorder model.
// Define FFT_REORDER_INDEX_EN to also exercise index_out.
module tb_fft_reorder;
    localparam int W    = 13;
    localparam int L    = 16;
    localparam int NP   = 512;
    localparam int NB   = NP / L;
    localparam int BVW  = 2 * W * L;
    localparam int PER  = 10;

    logic               clk;
    logic               rstn;
    logic               valid_in;
    logic signed [W-1:0] din_i  [0:L-1];
    logic signed [W-1:0] din_q  [0:L-1];
    logic               valid_out;
    logic signed [W-1:0] dout_i [0:L-1];
    logic signed [W-1:0] dout_q [0:L-1];
`ifdef FFT_REORDER_INDEX_EN
    logic [8:0]         index_out [0:L-1];
`endif

    int n_checks = 0;
    int n_errors = 0;
    int idle_bad = 0;

    logic [BVW-1:0] exp_q  [$];
    time            exp_tq [$];
    logic [BVW-1:0] obs_d  [$];
    time            obs_t  [$];
`ifdef FFT_REORDER_INDEX_EN
    logic [9*L-1:0] idx_q  [$];
`endif

    int frm_re [0:NP-1];
    int frm_im [0:NP-1];

    fft_reorder #(.WIDTH(W), .NUM(L), .N(NP)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .valid_in  (valid_in),
        .din_i     (din_i),
        .din_q     (din_q),
        .valid_out (valid_out),
        .dout_i    (dout_i),
        .dout_q    (dout_q)
`ifdef FFT_REORDER_INDEX_EN
        ,
        .index_out (index_out)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #(PER/2) clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int bitrev9(input int x);
        int y;
        y = 0;
        for (int k = 0; k < 9; k++) begin
            if (((x >> k) & 1) != 0) y = y | (1 << (8 - k));
        end
        return y;
    endfunction

    // Natural bin k of the frame was sent at input position bitrev9(k).
    function automatic logic [BVW-1:0] model_beat(input int b);
        logic [BVW-1:0] v;
        logic [W-1:0]   re;
        logic [W-1:0]   im;
        int             p;
        v = '0;
        for (int l = 0; l < L; l++) begin
            p  = bitrev9(b * L + l);
            re = W'(frm_re[p]);
            im = W'(frm_im[p]);
            v[l*2*W +: 2*W] = {re, im};
        end
        return v;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [BVW-1:0] beat;
        logic [BVW-1:0] e;
        time            et;
        int             nz;
        beat = '0;
        nz   = 0;
        for (int l = 0; l < L; l++) begin
            beat[l*2*W +: 2*W] = {dout_i[l], dout_q[l]};
            if (dout_i[l] != 0 || dout_q[l] != 0) nz++;
        end
        if (valid_out === 1'b1) begin
            obs_d.push_back(beat);
            obs_t.push_back($time);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected: got output beat at t=%0t, required no beat", $time);
            end else begin
                e  = exp_q.pop_front();
                et = exp_tq.pop_front();
                if (beat !== e) begin
                    n_errors++;
                    $display("FAIL sb_data: t=%0t got %h required %h", $time, beat, e);
                end
                n_checks++;
                if ($time != et) begin
                    n_errors++;
                    $display("FAIL sb_time: got beat at t=%0t, required t=%0t", $time, et);
                end
            end
        end else if (nz != 0) begin
            idle_bad++;
        end
`ifdef FFT_REORDER_INDEX_EN
        begin
            logic [9*L-1:0] iv;
            iv = '0;
            for (int l = 0; l < L; l++) iv[l*9 +: 9] = index_out[l];
            if (valid_out === 1'b1) idx_q.push_back(iv);
            else if (iv != '0) idle_bad++;
        end
`endif
    end

    // ---------------- drivers ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (8) @(posedge clk);
        #1;
    endtask

    // kind: 0 ramp, 1 impulse, 2 random.  gaps: 0 none, 1 alternate cycles, 2 random.
    task automatic drive_frame(input int kind, input int gaps, input int nbeats, output time cap);
        int idle;
        cap = 0;
        for (int p = 0; p < NP; p++) begin
            case (kind)
                0: begin frm_re[p] = p - 256; frm_im[p] = 255 - p; end
                1: begin frm_re[p] = (p == 1) ? 100 : 0; frm_im[p] = 0; end
                default: begin
                    frm_re[p] = int'($urandom_range(0, 8191)) - 4096;
                    frm_im[p] = int'($urandom_range(0, 8191)) - 4096;
                end
            endcase
        end
        for (int b = 0; b < nbeats; b++) begin
            idle = 0;
            if (gaps == 1 && b > 0) idle = 1;
            if (gaps == 2) idle = int'($urandom_range(0, 3));
            repeat (idle) begin
                valid_in = 1'b0;
                @(posedge clk);
                #1;
            end
            valid_in = 1'b1;
            for (int l = 0; l < L; l++) begin
                din_i[l] = W'(frm_re[b*L + l]);
                din_q[l] = W'(frm_im[b*L + l]);
            end
            @(posedge clk);
            cap = $time;
            #1;
        end
        valid_in = 1'b0;
        for (int l = 0; l < L; l++) begin
            din_i[l] = '0;
            din_q[l] = '0;
        end
        if (nbeats == NB) begin
            for (int b = 0; b < NB; b++) begin
                exp_q.push_back(model_beat(b));
                exp_tq.push_back(cap + PER + PER/2 + time'(b * PER));
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int nz;
        rstn     = 1'b0;
        valid_in = 1'b0;
        for (int l = 0; l < L; l++) begin
            din_i[l] = W'($urandom_range(0, 8191));
            din_q[l] = W'($urandom_range(0, 8191));
        end
        wait_cycles(3);
        nz = 0;
        for (int l = 0; l < L; l++) if (dout_i[l] != 0 || dout_q[l] != 0) nz++;
        n_checks++;
        if (valid_out !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_valid: got %b required 0", valid_out);
        end
        n_checks++;
        if (nz != 0) begin
            n_errors++;
            $display("FAIL reset_dout: got %0d nonzero lanes required 0", nz);
        end
        for (int l = 0; l < L; l++) begin
            din_i[l] = '0;
            din_q[l] = '0;
        end
        rstn = 1'b1;
        wait_cycles(2);
    endtask

    task automatic test_ramp();
        time cap;
        int  want;
        obs_d.delete();
        obs_t.delete();
        drive_frame(0, 0, NB, cap);
        wait_drain();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL ramp_drain: got %0d beats outstanding required 0", exp_q.size());
        end
        n_checks++;
        if (obs_d.size() != NB) begin
            n_errors++;
            $display("FAIL ramp_count: got %0d beats required %0d", obs_d.size(), NB);
        end else begin
            n_checks++;
            if (obs_t[0] != cap + PER + PER/2) begin
                n_errors++;
                $display("FAIL ramp_latency: got first beat t=%0t required t=%0t", obs_t[0], cap + PER + PER/2);
            end
            want = bitrev9(3 * L + 7) - 256;
            n_checks++;
            if (obs_d[3][7*2*W + W +: W] !== W'(want)) begin
                n_errors++;
                $display("FAIL ramp_b3l7: got %h required %h", obs_d[3][7*2*W + W +: W], W'(want));
            end
        end
    endtask

    task automatic test_impulse();
        time cap;
        int  nz;
        logic [2*W-1:0] lane0;
        obs_d.delete();
        obs_t.delete();
        drive_frame(1, 0, NB, cap);
        wait_drain();
        n_checks++;
        if (obs_d.size() != NB) begin
            n_errors++;
            $display("FAIL impulse_count: got %0d beats required %0d", obs_d.size(), NB);
        end else begin
            nz = 0;
            for (int b = 0; b < NB; b++)
                for (int l = 0; l < L; l++)
                    if (obs_d[b][l*2*W +: 2*W] != '0) nz++;
            lane0 = obs_d[16][2*W-1:0];
            n_checks++;
            if (lane0 !== {13'd100, 13'd0}) begin
                n_errors++;
                $display("FAIL impulse_b16l0: got %h required %h", lane0, {13'd100, 13'd0});
            end
            n_checks++;
            if (nz != 1) begin
                n_errors++;
                $display("FAIL impulse_nonzero: got %0d nonzero lanes required 1", nz);
            end
        end
    endtask

    task automatic test_back_to_back();
        time cap0;
        time cap;
        obs_d.delete();
        obs_t.delete();
        drive_frame(2, 0, NB, cap0);
        drive_frame(2, 0, NB, cap);
        drive_frame(2, 0, NB, cap);
        wait_drain();
        n_checks++;
        if (obs_t.size() != 3 * NB) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d beats required %0d", obs_t.size(), 3 * NB);
        end else begin
            n_checks++;
            if (obs_t[0] != cap0 + PER + PER/2 || obs_t[3*NB-1] - obs_t[0] != time'((3*NB - 1) * PER)) begin
                n_errors++;
                $display("FAIL b2b_span: got first t=%0t last t=%0t required first t=%0t span %0d",
                         obs_t[0], obs_t[3*NB-1], cap0 + PER + PER/2, (3*NB - 1) * PER);
            end
        end
    endtask

    task automatic test_gapped();
        time cap;
        obs_d.delete();
        obs_t.delete();
        drive_frame(0, 1, NB, cap);
        wait_drain();
        n_checks++;
        if (obs_t.size() != NB) begin
            n_errors++;
            $display("FAIL gapped_count: got %0d beats required %0d", obs_t.size(), NB);
        end else begin
            n_checks++;
            if (obs_t[NB-1] - obs_t[0] != time'((NB - 1) * PER)) begin
                n_errors++;
                $display("FAIL gapped_burst: got span %0t required %0d", obs_t[NB-1] - obs_t[0], (NB - 1) * PER);
            end
        end
        for (int f = 0; f < 3; f++) begin
            drive_frame(2, 2, NB, cap);
        end
        wait_drain();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL random_gaps_drain: got %0d beats outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        time cap;
        int  nz;
        drive_frame(2, 0, 10, cap);
        rstn = 1'b0;
        wait_cycles(2);
        rstn = 1'b1;
        wait_cycles(1);
        obs_d.delete();
        obs_t.delete();
        drive_frame(0, 0, NB, cap);
        repeat (11) @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        nz = 0;
        for (int l = 0; l < L; l++) if (dout_i[l] != 0 || dout_q[l] != 0) nz++;
        n_checks++;
        if (valid_out !== 1'b0 || nz != 0) begin
            n_errors++;
            $display("FAIL midread_reset: got valid_out=%b nonzero=%0d required 0 and 0", valid_out, nz);
        end
        n_checks++;
        if (obs_d.size() != 10) begin
            n_errors++;
            $display("FAIL midread_beats: got %0d beats before reset required 10", obs_d.size());
        end
        exp_q.delete();
        exp_tq.delete();
        wait_cycles(2);
        rstn = 1'b1;
        wait_cycles(1);
        obs_d.delete();
        obs_t.delete();
        drive_frame(2, 2, NB, cap);
        wait_drain();
        n_checks++;
        if (obs_d.size() != NB || exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL post_reset_frame: got %0d beats (%0d outstanding) required %0d (0)",
                     obs_d.size(), exp_q.size(), NB);
        end
    endtask

`ifdef FFT_REORDER_INDEX_EN
    task automatic test_index();
        time cap;
        idx_q.delete();
        drive_frame(2, 0, NB, cap);
        wait_drain();
        n_checks++;
        if (idx_q.size() != NB) begin
            n_errors++;
            $display("FAIL index_count: got %0d beats required %0d", idx_q.size(), NB);
        end else begin
            for (int l = 0; l < L; l++) begin
                n_checks++;
                if (idx_q[5][l*9 +: 9] !== 9'(80 + l)) begin
                    n_errors++;
                    $display("FAIL index_b5: lane %0d got %0d required %0d", l, idx_q[5][l*9 +: 9], 80 + l);
                end
            end
        end
    endtask
`endif

    task automatic test_idle_zero();
        n_checks++;
        if (idle_bad != 0) begin
            n_errors++;
            $display("FAIL idle_zero: got %0d idle cycles with nonzero outputs required 0", idle_bad);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_impulse();
        test_back_to_back();
        test_gapped();
        test_reset_mid();
`ifdef FFT_REORDER_INDEX_EN
        test_index();
`endif
        test_idle_zero();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
